// File: rtl/instr_ram_pipe.sv
// Instruction RAM with a fetch port of fixed LATENCY and a priority load write port.
// Fetch responses travel through a LATENCY-stage {valid, err, data} pipeline.
module instr_ram_pipe #(
    parameter int unsigned  DEPTH     = 8192,
    parameter logic [31:0]  BASE_ADDR = 32'h0000_0000,
    parameter int unsigned  LATENCY   = 1,
    localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             instr_req_i,
    input  logic [31:0]      instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [31:0]      instr_rdata_o,
    output logic             instr_err_o,
    input  logic             load_we_i,
    input  logic [IDX_W-1:0] load_addr_i,
    input  logic [31:0]      load_wdata_i
);

    localparam int unsigned DATA_W = 32;

    if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
        $error("instr_ram_pipe: LATENCY must be 1..3");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_ram_pipe: DEPTH must be a power of two >= 2");
    end

    logic [DATA_W-1:0]              mem_q [DEPTH];
    logic [31:0]                    off;
    logic                           in_range;
    logic [IDX_W-1:0]               idx;

    logic                           valid_d;
    logic                           err_d;
    logic [DATA_W-1:0]              data_d;
    logic [LATENCY-1:0]             valid_q;
    logic [LATENCY-1:0]             err_q;
    logic [LATENCY-1:0][DATA_W-1:0] data_q;

    // Loads take priority over fetches; nothing is granted while in reset.
    assign instr_gnt_o = instr_req_i & ~load_we_i & rst_ni;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR fail the >= test.
    assign off      = instr_addr_i - BASE_ADDR;
    assign in_range = (instr_addr_i >= BASE_ADDR)
                   && ((off >> 2) < 32'(DEPTH))
                   && (off[1:0] == 2'b00);
    assign idx      = off[IDX_W+1:2];

    // Pipeline entry: sampled word or an error response, zeros when idle.
    always_comb begin
        valid_d = instr_gnt_o;
        err_d   = 1'b0;
        data_d  = '0;
        if (instr_gnt_o) begin
            if (in_range) begin
                data_d = mem_q[idx];
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Storage is not reset; contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem_q[load_addr_i] <= load_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            err_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= valid_d;
            err_q[0]   <= err_d;
            data_q[0]  <= data_d;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign instr_rvalid_o = valid_q[LATENCY-1];
    assign instr_err_o    = err_q[LATENCY-1];
    assign instr_rdata_o  = data_q[LATENCY-1];

endmodule

// File: tb/tb_instr_ram_pipe.sv
// Bench for instr_ram_pipe: three instances (LATENCY 1, 2, 3) share stimulus and
// are compared against a grant-history model of the fetch port.
module tb_instr_ram_pipe;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned IW    = 6;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             req   = 1'b0;
    logic [31:0]      addr  = '0;
    logic             we    = 1'b0;
    logic [IW-1:0]    la    = '0;
    logic [31:0]      wd    = '0;

    logic             gnt [3];
    logic             rv  [3];
    logic             er  [3];
    logic [31:0]      rd  [3];

    int errors = 0;
    int checks = 0;

    // Model: memory image plus the last three grant outcomes (index 0 = newest edge).
    logic [31:0] mm [DEPTH];
    logic        hv [3];
    logic        he [3];
    logic [31:0] hd [3];

    always #5 clk = ~clk;

    instr_ram_pipe #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rdata_o(rd[0]),
        .instr_err_o(er[0]), .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd));
    instr_ram_pipe #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) u_l2 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rdata_o(rd[1]),
        .instr_err_o(er[1]), .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd));
    instr_ram_pipe #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[2]), .instr_rvalid_o(rv[2]), .instr_rdata_o(rd[2]),
        .instr_err_o(er[2]), .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd));

    task automatic clear_hist();
        for (int k = 0; k < 3; k++) begin
            hv[k] = 1'b0; he[k] = 1'b0; hd[k] = '0;
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic w,
                         input logic [IW-1:0] l, input logic [31:0] d);
        req = r; addr = a; we = w; la = l; wd = d;
    endtask

    // Advance one rising edge, apply the fetch/load rules to the model, settle 1ns.
    task automatic tick();
        logic             v;
        logic             e;
        logic [31:0]      d;
        longint unsigned  a;
        @(posedge clk);
        a = {32'h0, addr};
        v = rst_n && req && !we;
        e = 1'b0;
        d = '0;
        if (v) begin
            if (a >= BASE && a < BASE + DEPTH * 4 && (a % 4) == 0)
                d = mm[int'((a - BASE) / 4)];
            else
                e = 1'b1;
        end
        if (we) mm[la] = wd;
        for (int k = 2; k > 0; k--) begin
            hv[k] = hv[k-1]; he[k] = he[k-1]; hd[k] = hd[k-1];
        end
        hv[0] = v; he[0] = e; hd[0] = d;
        if (!rst_n) clear_hist();
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, BASE, 1'b0, '0, '0);
        repeat (2) tick();
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (gnt[l] !== 1'b0 || rv[l] !== 1'b0 || er[l] !== 1'b0 || rd[l] !== 32'h0) begin
                errors++;
                $display("FAIL reset lat=%0d got gnt=%b v=%b e=%b d=%h want 0 0 0 0",
                         l + 1, gnt[l], rv[l], er[l], rd[l]);
            end
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        logic [31:0] v;
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = (i < 4) ? 32'(i + 1) : (i == 4) ? 32'hDEAD_BEEF : (i == 5) ? 32'h11 : $urandom;
            drive(1'b0, '0, 1'b1, IW'(i), v);
            tick();
            for (int l = 0; l < 3; l++) begin
                checks++;
                if (rv[l] !== 1'b0) begin
                    errors++;
                    $display("FAIL load_idle lat=%0d got rvalid=%b want 0", l + 1, rv[l]);
                end
            end
        end
        drive(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_single();
        drive(1'b1, BASE + 32'd16, 1'b0, '0, '0);
        #1;
        checks++;
        if (gnt[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt got %b want 1", gnt[0]);
        end
        tick();
        drive(1'b0, '0, 1'b0, '0, '0);
        checks++;
        if (rv[0] !== 1'b1 || er[0] !== 1'b0 || rd[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_resp got v=%b e=%b d=%h want 1 0 deadbeef", rv[0], er[0], rd[0]);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int l = 0; l < 3; l++) begin
                checks++;
                if (rv[l] !== hv[l] || er[l] !== he[l] || rd[l] !== hd[l]) begin
                    errors++;
                    $display("FAIL single_model lat=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                             l + 1, rv[l], er[l], rd[l], hv[l], he[l], hd[l]);
                end
            end
        end
    endtask

    task automatic test_stream();
        logic        sv [8];
        logic [31:0] sd [8];
        for (int j = 0; j < 8; j++) begin
            if (j < 4) drive(1'b1, BASE + 32'(4 * j), 1'b0, '0, '0);
            else       drive(1'b0, '0, 1'b0, '0, '0);
            #1;
            if (j < 4) begin
                checks++;
                if (gnt[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_gnt cycle=%0d got %b want 1", j, gnt[2]);
                end
            end
            tick();
            sv[j] = rv[2];
            sd[j] = rd[2];
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (sv[j] !== (j >= 2 && j <= 5) || sd[j] !== ((j >= 2 && j <= 5) ? 32'(j - 1) : 32'h0)) begin
                errors++;
                $display("FAIL stream_lat3 edge=%0d got v=%b d=%h", j, sv[j], sd[j]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] bad [3];
        bad[0] = BASE + 32'(DEPTH * 4);
        bad[1] = BASE - 32'd4;
        bad[2] = BASE + 32'd2;
        for (int b = 0; b < 3; b++) begin
            drive(1'b1, bad[b], 1'b0, '0, '0);
            tick();
            drive(1'b0, '0, 1'b0, '0, '0);
            checks++;
            if (rv[0] !== 1'b1 || er[0] !== 1'b1 || rd[0] !== 32'h0) begin
                errors++;
                $display("FAIL err_resp addr=%h got v=%b e=%b d=%h want 1 1 0", bad[b], rv[0], er[0], rd[0]);
            end
            for (int c = 0; c < 3; c++) begin
                tick();
                for (int l = 0; l < 3; l++) begin
                    checks++;
                    if (rv[l] !== hv[l] || er[l] !== he[l] || rd[l] !== hd[l]) begin
                        errors++;
                        $display("FAIL err_model lat=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                                 l + 1, rv[l], er[l], rd[l], hv[l], he[l], hd[l]);
                    end
                end
            end
        end
    endtask

    task automatic test_priority();
        int n = 0;
        drive(1'b1, BASE + 32'd8, 1'b1, IW'(10), 32'hA5A5_0001);
        #1;
        checks++;
        if (gnt[0] !== 1'b0) begin
            errors++;
            $display("FAIL prio_block got gnt=%b want 0", gnt[0]);
        end
        tick();
        n += int'(rv[0]);
        drive(1'b1, BASE + 32'd8, 1'b0, '0, '0);
        #1;
        checks++;
        if (gnt[0] !== 1'b1) begin
            errors++;
            $display("FAIL prio_grant got gnt=%b want 1", gnt[0]);
        end
        tick();
        n += int'(rv[0]);
        drive(1'b0, '0, 1'b0, '0, '0);
        for (int c = 0; c < 4; c++) begin
            tick();
            n += int'(rv[0]);
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL prio_count got %0d responses want 1", n);
        end
    endtask

    task automatic test_write_after_grant();
        logic [31:0] got [$];
        for (int j = 0; j < 6; j++) begin
            case (j)
                0, 2:    drive(1'b1, BASE + 32'd20, 1'b0, '0, '0);
                1:       drive(1'b0, '0, 1'b1, IW'(5), 32'h22);
                default: drive(1'b0, '0, 1'b0, '0, '0);
            endcase
            tick();
            if (rv[1] === 1'b1) got.push_back(rd[1]);
        end
        checks++;
        if (got.size() != 2 || got[0] !== 32'h11 || got[1] !== 32'h22) begin
            errors++;
            $display("FAIL war_order got n=%0d first=%h second=%h want 2 11 22", got.size(),
                     (got.size() > 0) ? got[0] : 32'hx, (got.size() > 1) ? got[1] : 32'hx);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15) * 4);
            1:       return BASE - 32'($urandom_range(1, 8) * 4);
            2:       return BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            default: return BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
        endcase
    endfunction

    task automatic test_random();
        logic held;
        for (int c = 0; c < 400; c++) begin
            held = req && we;
            we = ($urandom_range(0, 3) == 0);
            la = IW'($urandom_range(0, DEPTH - 1));
            wd = $urandom;
            if (!held) begin
                req  = ($urandom_range(0, 3) != 0);
                addr = rand_addr();
            end
            #1;
            checks++;
            if (gnt[1] !== (req && !we)) begin
                errors++;
                $display("FAIL rand_gnt cycle=%0d got %b want %b", c, gnt[1], req && !we);
            end
            tick();
            for (int l = 0; l < 3; l++) begin
                checks++;
                if (rv[l] !== hv[l] || er[l] !== he[l] || rd[l] !== hd[l]) begin
                    errors++;
                    $display("FAIL rand_model cycle=%0d lat=%0d got v=%b e=%b d=%h want v=%b e=%b d=%h",
                             c, l + 1, rv[l], er[l], rd[l], hv[l], he[l], hd[l]);
                end
            end
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        repeat (3) tick();
    endtask

    task automatic test_reset_inflight();
        int n = 0;
        drive(1'b1, BASE + 32'd12, 1'b0, '0, '0);
        tick();
        #2;
        rst_n = 1'b0;
        clear_hist();
        #1;
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (rv[l] !== 1'b0 || rd[l] !== 32'h0 || er[l] !== 1'b0) begin
                errors++;
                $display("FAIL rst_async lat=%0d got v=%b e=%b d=%h want 0 0 0", l + 1, rv[l], er[l], rd[l]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int l = 0; l < 3; l++) n += int'(rv[l]);
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int l = 0; l < 3; l++) n += int'(rv[l]);
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL rst_discard got %0d stray responses want 0", n);
        end
        drive(1'b1, BASE + 32'd12, 1'b0, '0, '0);
        #1;
        checks++;
        if (gnt[1] !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_gnt got %b want 1", gnt[1]);
        end
        tick();
        drive(1'b0, '0, 1'b0, '0, '0);
        tick();
        checks++;
        if (rv[1] !== 1'b1 || rd[1] !== mm[3] || er[1] !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_resp got v=%b e=%b d=%h want 1 0 %h", rv[1], er[1], rd[1], mm[3]);
        end
    endtask

    initial begin
        clear_hist();
        test_reset();
        test_load();
        test_single();
        test_stream();
        test_errors();
        test_priority();
        test_write_after_grant();
        test_random();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
